// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states, flag bit positions.
// Opcode byte layout: [2:0] op, [3] chain (accumulator as A), [7:4] reserved.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_AND    = 3'd2,
        OP_OR     = 3'd3,
        OP_XOR    = 3'd4,
        OP_SHL    = 3'd5,
        OP_SHR    = 3'd6,
        OP_PASS_B = 3'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GET_A = 3'd1,
        S_GET_B = 3'd2,
        S_EXEC  = 3'd3,
        S_RESP  = 3'd4
    } seq_state_e;

    localparam int FLAG_ZERO    = 0;
    localparam int FLAG_CARRY   = 1;
    localparam int FLAG_TIMEOUT = 2;
    localparam int FLAG_ERR     = 3;

    localparam int OPC_CHAIN_BIT = 3;

    function automatic logic opcode_legal(input logic [7:0] opc, input logic chain_en);
        return (opc[7:4] == 4'h0) && (chain_en || !opc[OPC_CHAIN_BIT]);
    endfunction

endpackage

// File: rtl/alu_seq_timeout.sv
// Counts consecutive idle cycles while a command is partially received; expired fires
// combinationally on the TIMEOUT_CYCLES-th idle cycle (never when TIMEOUT_CYCLES is 0).
module alu_seq_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic idle,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (active && idle) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && active && idle
                     && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Collects opcode/A/B bytes, drives an external ALU and returns a registered result; 2 cycles B->out_valid,
// one command in flight, in_ready low from EXEC until out handshake. ALU_SEQ_ACC_CHAIN_EN adds accumulator chaining.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [2:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_y,
    input  logic       alu_c,
    output logic [7:0] out_data,
    output logic [3:0] out_flags,
    output logic       out_valid,
    input  logic       out_ready
);

`ifdef ALU_SEQ_ACC_CHAIN_EN
    localparam logic CHAIN_EN = 1'b1;
    logic [7:0] acc_q, acc_d;
`else
    localparam logic CHAIN_EN = 1'b0;
`endif

    seq_state_e state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [7:0] a_q, a_d, b_q, b_d, data_q, data_d;
    logic [3:0] flags_q, flags_d;
    logic       xfer, expired, opc_ok;

    assign xfer   = in_valid && in_ready;
    assign opc_ok = opcode_legal(in_data, CHAIN_EN);

    alu_seq_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .active  ((state_q == S_GET_A) || (state_q == S_GET_B)),
        .idle    (!in_valid),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // An accepted byte always wins over a same-cycle timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    if (!opc_ok)                            state_d = S_RESP;
                    else if (CHAIN_EN && in_data[OPC_CHAIN_BIT]) state_d = S_GET_B;
                    else                                    state_d = S_GET_A;
                end
            end
            S_GET_A: begin
                if (xfer)         state_d = S_GET_B;
                else if (expired) state_d = S_RESP;
            end
            S_GET_B: begin
                if (xfer)         state_d = S_EXEC;
                else if (expired) state_d = S_RESP;
            end
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE) || (state_q == S_GET_A) || (state_q == S_GET_B);
        out_valid = (state_q == S_RESP);
    end

    always_comb begin
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        flags_d = flags_q;
`ifdef ALU_SEQ_ACC_CHAIN_EN
        acc_d   = acc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    if (opc_ok) begin
                        op_d = in_data[2:0];
`ifdef ALU_SEQ_ACC_CHAIN_EN
                        if (in_data[OPC_CHAIN_BIT]) a_d = acc_q;
`endif
                    end else begin
                        data_d            = 8'h00;
                        flags_d           = 4'h0;
                        flags_d[FLAG_ERR] = 1'b1;
                    end
                end
            end
            S_GET_A, S_GET_B: begin
                if (xfer) begin
                    if (state_q == S_GET_A) a_d = in_data;
                    else                    b_d = in_data;
                end else if (expired) begin
                    data_d                = 8'h00;
                    flags_d               = 4'h0;
                    flags_d[FLAG_TIMEOUT] = 1'b1;
                end
            end
            S_EXEC: begin
                data_d              = alu_y;
                flags_d             = 4'h0;
                flags_d[FLAG_CARRY] = alu_c;
                flags_d[FLAG_ZERO]  = (alu_y == 8'h00);
`ifdef ALU_SEQ_ACC_CHAIN_EN
                acc_d               = alu_y;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            flags_q <= '0;
`ifdef ALU_SEQ_ACC_CHAIN_EN
            acc_q   <= '0;
`endif
        end else begin
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            flags_q <= flags_d;
`ifdef ALU_SEQ_ACC_CHAIN_EN
            acc_q   <= acc_d;
`endif
        end
    end

    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign out_data  = data_q;
    assign out_flags = flags_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU; TIMEOUT_CYCLES fixed at 4.
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] alu_op;
    logic [7:0] alu_a, alu_b, alu_y;
    logic       alu_c;
    logic [7:0] out_data;
    logic [3:0] out_flags;
    logic       out_valid;
    logic       out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_y     (alu_y),
        .alu_c     (alu_c),
        .out_data  (out_data),
        .out_flags (out_flags),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Reference ALU: carry is carry-out for ADD, borrow for SUB, shifted-out bit for shifts.
    always_comb begin
        alu_y = 8'h00;
        alu_c = 1'b0;
        case (alu_op)
            3'd0: {alu_c, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1: begin alu_y = alu_a - alu_b; alu_c = (alu_a < alu_b); end
            3'd2: alu_y = alu_a & alu_b;
            3'd3: alu_y = alu_a | alu_b;
            3'd4: alu_y = alu_a ^ alu_b;
            3'd5: begin alu_y = {alu_a[6:0], 1'b0}; alu_c = alu_a[7]; end
            3'd6: begin alu_y = {1'b0, alu_a[7:1]}; alu_c = alu_a[0]; end
            default: alu_y = alu_b;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_byte: in_ready stayed 0 for %0d cycles, expected 1", n);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_resp(output int k);
        k = 0;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic take_resp();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  in_ready,  1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"},  out_data,  0);
        check({tag, "_out_flags"}, out_flags, 0);
        check({tag, "_alu_op"},    alu_op,    0);
        check({tag, "_alu_a"},     alu_a,     0);
        check({tag, "_alu_b"},     alu_b,     0);
    endtask

    typedef struct {
        logic [7:0] opc;
        logic [7:0] a;
        logic [7:0] b;
        bit         has_ab;
        logic [7:0] exp_data;
        logic [3:0] exp_flags;
        int         exp_lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;

        // flags are {err, timeout, carry, zero}; latency counts from the cycle the last byte is offered
        vecs[0]  = '{8'h00, 8'h05, 8'h03, 1'b1, 8'h08, 4'b0000, 2};
        vecs[1]  = '{8'h01, 8'h03, 8'h03, 1'b1, 8'h00, 4'b0001, 2};
        vecs[2]  = '{8'h00, 8'hFF, 8'h01, 1'b1, 8'h00, 4'b0011, 2};
        vecs[3]  = '{8'h80, 8'h00, 8'h00, 1'b0, 8'h00, 4'b1000, 1};
        vecs[4]  = '{8'h02, 8'hF0, 8'h3C, 1'b1, 8'h30, 4'b0000, 2};
        vecs[5]  = '{8'h03, 8'hF0, 8'h0F, 1'b1, 8'hFF, 4'b0000, 2};
        vecs[6]  = '{8'h04, 8'hAA, 8'hAA, 1'b1, 8'h00, 4'b0001, 2};
        vecs[7]  = '{8'h05, 8'h81, 8'h00, 1'b1, 8'h02, 4'b0010, 2};
        vecs[8]  = '{8'h06, 8'h03, 8'h00, 1'b1, 8'h01, 4'b0010, 2};
        vecs[9]  = '{8'h07, 8'h11, 8'h22, 1'b1, 8'h22, 4'b0000, 2};
        vecs[10] = '{8'h01, 8'h02, 8'h03, 1'b1, 8'hFF, 4'b0010, 2};
        vecs[11] = '{8'h40, 8'h00, 8'h00, 1'b0, 8'h00, 4'b1000, 1};

        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("reset");

        for (int i = 0; i < 12; i++) begin
            send_byte(vecs[i].opc);
            if (vecs[i].has_ab) begin
                send_byte(vecs[i].a);
                send_byte(vecs[i].b);
            end
            wait_resp(k);
            check($sformatf("v%0d_latency", i), k + 1, vecs[i].exp_lat);
            check($sformatf("v%0d_out_data", i), out_data, vecs[i].exp_data);
            check($sformatf("v%0d_out_flags", i), out_flags, vecs[i].exp_flags);
            take_resp();
            check($sformatf("v%0d_idle_after", i), out_valid, 0);
        end

        // Timeout: opcode then silence -> abort after the 4th idle cycle.
        send_byte(8'h00);
        wait_resp(k);
        check("timeout_cycles", k, 4);
        check("timeout_out_data", out_data, 8'h00);
        check("timeout_out_flags", out_flags, 4'b0100);
        take_resp();

        // Byte arriving on the 4th idle cycle beats the timeout.
        send_byte(8'h00);
        repeat (3) @(negedge clk);
        check("timeout_edge_no_resp", out_valid, 0);
        send_byte(8'h10);
        check("timeout_edge_still_busy", out_valid, 0);
        send_byte(8'h20);
        wait_resp(k);
        check("timeout_edge_latency", k + 1, 2);
        check("timeout_edge_out_data", out_data, 8'h30);
        check("timeout_edge_out_flags", out_flags, 4'b0000);
        take_resp();

        // Consumer stalls for 10 cycles.
        send_byte(8'h00);
        send_byte(8'h21);
        send_byte(8'h13);
        wait_resp(k);
        for (int c = 0; c < 10; c++) begin
            check($sformatf("stall%0d_out_valid", c), out_valid, 1);
            check($sformatf("stall%0d_out_data", c), out_data, 8'h34);
            check($sformatf("stall%0d_in_ready", c), in_ready, 0);
            @(negedge clk);
        end
        check("stall_alu_op", alu_op, 3'd0);
        check("stall_alu_a", alu_a, 8'h21);
        check("stall_alu_b", alu_b, 8'h13);
        take_resp();
        check("stall_release_out_valid", out_valid, 0);
        check("stall_release_in_ready", in_ready, 1);

        // Reset while waiting for B discards the partial command.
        send_byte(8'h01);
        send_byte(8'h09);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_values("midrst");
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h02);
        wait_resp(k);
        check("midrst_fresh_out_data", out_data, 8'h03);
        take_resp();

        // Reset while a response is pending drops it.
        send_byte(8'h80);
        check("pendrst_before", out_valid, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_values("pendrst");

`ifdef ALU_SEQ_ACC_CHAIN_EN
        send_byte(8'h00);
        send_byte(8'h05);
        send_byte(8'h03);
        wait_resp(k);
        check("chain_first_out_data", out_data, 8'h08);
        take_resp();
        send_byte(8'h08);
        send_byte(8'h02);
        wait_resp(k);
        check("chain_latency", k + 1, 2);
        check("chain_out_data", out_data, 8'h0A);
        check("chain_out_flags", out_flags, 4'b0000);
        take_resp();
`else
        send_byte(8'h08);
        wait_resp(k);
        check("chainbit_latency", k + 1, 1);
        check("chainbit_out_data", out_data, 8'h00);
        check("chainbit_out_flags", out_flags, 4'b1000);
        take_resp();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning idle cycles allowed mid-command before abort (0 = timeout disabled).
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_data  input  8  command byte stream (opcode, A, B).
REQ-005 SHALL have port in_valid  input  1  in_data valid.
REQ-006 SHALL have port in_ready  output  1  sequencer accepts byte this cycle.
REQ-007 SHALL have port alu_op  output  3  opcode to external ALU.
REQ-008 SHALL have port alu_a  output  8  operand A to ALU.
REQ-009 SHALL have port alu_b  output  8  operand B to ALU.
REQ-010 SHALL have port alu_y  input  8  combinational ALU result.
REQ-011 SHALL have port alu_c  input  1  ALU carry/borrow.
REQ-012 SHALL have port out_data  output  8  response result byte.
REQ-013 SHALL have port out_flags  output  4  {err, timeout, carry, zero}.
REQ-014 SHALL have port out_valid  output  1  response valid.
REQ-015 SHALL have port out_ready  input  1  consumer accepts response.

Function
REQ-016 SHALL implement FSM states IDLE, GET_A, GET_B, EXEC, RESP.
REQ-017 SHALL transfer an input byte only on a cycle with in_valid and in_ready both high; in_ready high exactly in IDLE, GET_A, GET_B.
REQ-018 SHALL decode opcode byte as [2:0] op, [3] chain, [7:4] reserved.
REQ-019 SHALL, in IDLE on accepted opcode, latch op and go to GET_A (chain=0) or GET_B (chain=1, macro enabled).
REQ-020 SHALL, on opcode with reserved bits nonzero (or bit3 set with macro disabled), skip the ALU and go to RESP with out_data=0x00, err=1.
REQ-021 SHALL latch A in GET_A then go to GET_B; latch B in GET_B then go to EXEC.
REQ-022 SHALL hold alu_op/alu_a/alu_b stable from EXEC entry until return to IDLE.
REQ-023 SHALL, in EXEC (one cycle), register alu_y into out_data, alu_c into carry, (alu_y==0) into zero, then go to RESP; latency last B byte accepted to out_valid = 2 cycles.
REQ-024 SHALL assert out_valid only in RESP, holding out_data/out_flags stable until out_valid && out_ready, then return to IDLE.
REQ-025 SHALL accept the next opcode no earlier than the cycle after the response handshake (no overlap).
REQ-026 SHALL count consecutive cycles in GET_A/GET_B with in_valid low, clearing on every accepted byte.
REQ-027 SHALL, when the count reaches TIMEOUT_CYCLES (nonzero), abort to RESP with out_data=0x00, timeout=1, err=0, carry=0, zero=0.
REQ-028 SHALL give an accepted byte priority over timeout in the same cycle.
REQ-029 SHALL update the accumulator register with out_data only on successful EXEC (not err/timeout).

Reset
REQ-030 SHALL, with rst_n low at a clock edge, enter IDLE and clear in_ready... to 1 after reset release; out_valid=0, out_data=0x00, out_flags=0x0, alu_op/alu_a/alu_b=0, accumulator=0, timeout counter=0.
REQ-031 SHALL discard any partial command or pending response when reset is asserted mid-operation.

Configuration
REQ-032 SHALL, with macro ALU_SEQ_ACC_CHAIN_EN defined, support chain=1: skip GET_A and use accumulator as operand A.
REQ-033 SHALL, without ALU_SEQ_ACC_CHAIN_EN, omit the accumulator and treat opcode bit3 as reserved (REQ-020).

Structure
REQ-034 SHALL place op encodings (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 PASS_B), FSM state typedef and flag bit indices in shared package alu_seq_pkg.
REQ-035 SHALL implement the timeout counter as sub-module alu_seq_timeout; ALU remains external.

Verification
REQ-036 SHALL cover: bytes 0x00,0x05,0x03 with ALU model -> out_data=0x08, flags=0b0000, out_valid 2 cycles after B.
REQ-037 SHALL cover: 0x01,0x03,0x03 -> out_data=0x00, zero=1; 0x00,0xFF,0x01 -> out_data=0x00, carry=1, zero=1.
REQ-038 SHALL cover: opcode 0x80 -> immediate response out_data=0x00, err=1, no A/B bytes consumed.
REQ-039 SHALL cover: TIMEOUT_CYCLES=4, send 0x00 then nothing -> RESP after 4 idle cycles with timeout=1; a byte arriving on cycle 4 is accepted instead.
REQ-040 SHALL cover: out_ready held low 10 cycles -> out_valid/out_data stable, in_ready=0 throughout; reset asserted mid-GET_B -> IDLE, all outputs at reset values.
REQ-041 SHALL cover (macro on): 0x00,0x05,0x03 then 0x08,0x02 -> second result 0x0A; macro off: 0x08 -> err=1.
